// File: rtl/data_sync_tx_pkg.sv
// Shared types and helpers for the source side of the bus-synchronizer handshake.
package data_sync_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_e;

    // Ceiling log2, valid for values up to 2**31.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Timeout counter width: enough to hold TIMEOUT, never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        int w;
        w = clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/data_sync_tx_bit_sync.sv
// Generic single-bit synchronizer: NUM_STAGES flops, output is the last stage.
// Latency NUM_STAGES edges from an input change to sync_out; no backpressure.
module bit_sync #(
    parameter int NUM_STAGES = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic sync_out
);

    logic [NUM_STAGES-1:0] sync_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[NUM_STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_tx.sv
// Source end of a four-phase req/ack bus synchronizer: holds one word on tx_bus under tx_req.
// Accept-to-req is one edge; in_ready stays low from accept until the ack has returned to zero.
import data_sync_tx_pkg::*;

module data_sync_tx #(
    parameter int NUM_STAGES = 3,
    parameter int BUS_WIDTH  = 8,
    parameter int TIMEOUT    = 0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] tx_bus,
    output logic                 tx_req,
    input  logic                 ack_async,
    output logic                 done,
    output logic                 timeout_err
);

    localparam int              CNT_W    = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e               state_q, state_d;
    logic [BUS_WIDTH-1:0] bus_q, bus_d;
    logic                 req_q, req_d;
    logic                 done_q, done_d;
    logic                 to_q, to_d;
    logic                 abort_q, abort_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 ack_sync;
    logic                 accept;
    logic                 timeout_hit;

    bit_sync #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (ack_async),
        .sync_out (ack_sync)
    );

    // A stale ack from a previous transfer keeps the block from starting a new one.
    assign in_ready    = (state_q == ST_IDLE) & ~ack_sync;
    assign accept      = in_valid & in_ready;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        bus_d   = bus_q;
        req_d   = req_q;
        done_d  = 1'b0;
        to_d    = 1'b0;
        abort_d = abort_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    bus_d   = in_data;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_sync) begin
                    req_d   = 1'b0;
                    abort_d = 1'b0;
                    state_d = ST_WAIT_LOW;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    to_d    = 1'b1;
                    abort_d = 1'b1;
                    state_d = ST_WAIT_LOW;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_LOW: begin
                if (!ack_sync) begin
                    done_d  = ~abort_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            bus_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            to_q    <= 1'b0;
            abort_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_d;
            req_q   <= req_d;
            done_q  <= done_d;
            to_q    <= to_d;
            abort_q <= abort_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_bus      = bus_q;
    assign tx_req      = req_q;
    assign done        = done_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// Directed and randomized bench for data_sync_tx against a handshake-phase reference model.
module tb_data_sync_tx;

    localparam int NS = 3;
    localparam int BW = 8;
    localparam int TO = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] tx_bus;
    logic          tx_req;
    logic          ack_async = 1'b0;
    logic          done;
    logic          timeout_err;

    data_sync_tx #(
        .NUM_STAGES (NS),
        .BUS_WIDTH  (BW),
        .TIMEOUT    (TO)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .tx_bus      (tx_bus),
        .tx_req      (tx_req),
        .ack_async   (ack_async),
        .done        (done),
        .timeout_err (timeout_err)
    );

    initial forever #5 CLK = ~CLK;

    // Reference model: handshake phase 0=idle, 1=requesting, 2=releasing.
    int          m_phase;
    bit          m_req, m_done, m_to, m_abort;
    logic [BW-1:0] m_bus;
    int          m_wait;
    bit          ack_hist[$];  // ack_async samples; front is what the handshake logic reacts to
    bit          dest_q[$];    // destination: ack = tx_req delayed 3 cycles
    int          dest_mode;    // 0: delayed-req destination, 1: ack forced to ack_force
    bit          ack_force;

    int n_chk  = 0;
    int n_pass = 0;
    int done_cnt = 0;
    int to_cnt   = 0;
    int req_hi_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    endtask

    function automatic bit m_ready();
        return (m_phase == 0) && !ack_hist[0];
    endfunction

    task automatic model_reset();
        m_phase = 0; m_req = 0; m_done = 0; m_to = 0; m_abort = 0;
        m_bus = '0; m_wait = 0;
        ack_hist.delete();
        repeat (NS) ack_hist.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit seen;
        seen = ack_hist.pop_front();
        ack_hist.push_back(ack_async);
        m_done = 0;
        m_to   = 0;
        case (m_phase)
            0: if (in_valid && !seen) begin
                m_bus = in_data; m_req = 1; m_phase = 1; m_wait = 0;
            end
            1: if (seen) begin
                m_req = 0; m_phase = 2; m_abort = 0;
            end else begin
                m_wait++;
                if (TO != 0 && m_wait == TO) begin
                    m_req = 0; m_to = 1; m_phase = 2; m_abort = 1;
                end
            end
            default: if (!seen) begin
                m_phase = 0; m_done = !m_abort;
            end
        endcase
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".tx_req"},      32'(tx_req),      32'(m_req));
        chk({tag, ".tx_bus"},      32'(tx_bus),      32'(m_bus));
        chk({tag, ".done"},        32'(done),        32'(m_done));
        chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(m_to));
        chk({tag, ".in_ready"},    32'(in_ready),    32'(m_ready()));
    endtask

    task automatic dest_drive();
        bit d;
        d = dest_q.pop_front();
        dest_q.push_back(m_req);
        ack_async = (dest_mode == 0) ? d : ack_force;
    endtask

    task automatic step(input string tag);
        @(posedge CLK);
        if (RST) model_edge();
        #1;
        compare_all(tag);
        if (m_done) done_cnt++;
        if (m_to) to_cnt++;
        if (tx_req) req_hi_cnt++;
        dest_drive();
    endtask

    task automatic reset_now(input string tag);
        RST = 1'b0;
        model_reset();
        #1;
        compare_all(tag);
    endtask

    initial begin
        int d0, t0;
        dest_mode = 0;
        ack_force = 0;
        repeat (3) dest_q.push_back(1'b0);

        // Reset with in_valid held high: nothing may be accepted.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        model_reset();
        #1;
        compare_all("reset");
        repeat (3) step("in_reset");
        RST = 1'b1;
        in_valid = 1'b0;
        step("post_reset");

        // Single transfer.
        in_data = 8'hA5; in_valid = 1'b1;
        step("single_accept");
        chk("single_bus", 32'(tx_bus), 32'h0A5);
        chk("single_req", 32'(tx_req), 32'h1);
        in_valid = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 40 && done_cnt == d0; i++) step("single");
        chk("single_done_seen", 32'(done_cnt - d0), 32'd1);
        chk("single_ready_with_done", 32'(in_ready), 32'h1);
        repeat (3) step("single_tail");

        // Back-to-back with data changing mid-handshake.
        in_data = 8'h11; in_valid = 1'b1;
        step("b2b_accept");
        repeat (4) step("b2b_hold");
        in_data = 8'h22;
        chk("b2b_first_intact", 32'(tx_bus), 32'h011);
        d0 = done_cnt;
        for (int i = 0; i < 40 && done_cnt == d0; i++) step("b2b_first");
        chk("b2b_first_done", 32'(done_cnt - d0), 32'd1);
        step("b2b_second_accept");
        chk("b2b_second_bus", 32'(tx_bus), 32'h022);
        in_valid = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 40 && done_cnt == d0; i++) step("b2b_second");
        chk("b2b_second_done", 32'(done_cnt - d0), 32'd1);
        repeat (3) step("b2b_tail");

        // Timeout with a dead destination, then a normal transfer.
        dest_mode = 1; ack_force = 0;
        d0 = done_cnt; t0 = to_cnt;
        in_data = 8'h3C; in_valid = 1'b1;
        step("to_accept");
        in_valid = 1'b0;
        repeat (25) step("to_wait");
        chk("to_pulse_count", 32'(to_cnt - t0), 32'd1);
        chk("to_no_done", 32'(done_cnt - d0), 32'd0);
        dest_mode = 0;
        in_data = 8'h5A; in_valid = 1'b1;
        step("after_to_accept");
        in_valid = 1'b0;
        d0 = done_cnt;
        for (int i = 0; i < 40 && done_cnt == d0; i++) step("after_to");
        chk("after_to_done", 32'(done_cnt - d0), 32'd1);
        repeat (3) step("after_to_tail");

        // Stale ack blocks acceptance.
        dest_mode = 1; ack_force = 1;
        repeat (5) step("stale_rise");
        in_data = 8'h77; in_valid = 1'b1;
        repeat (4) step("stale_block");
        chk("stale_ready_low", 32'(in_ready), 32'h0);
        chk("stale_no_req", 32'(tx_req), 32'h0);
        ack_force = 0;
        repeat (6) step("stale_release");
        chk("stale_accepted_bus", 32'(tx_bus), 32'h077);
        in_valid = 1'b0;
        dest_mode = 0;
        repeat (30) step("stale_finish");

        // Reset in the middle of a request.
        in_data = 8'h99; in_valid = 1'b1;
        step("mid_accept");
        in_valid = 1'b0;
        repeat (2) step("mid_req");
        #2;
        reset_now("mid_reset");
        chk("mid_reset_req_low", 32'(tx_req), 32'h0);
        step("mid_in_reset");
        RST = 1'b1;
        req_hi_cnt = 0;
        repeat (20) step("mid_after");
        chk("mid_no_rereq", 32'(req_hi_cnt), 32'd0);

        // Randomized traffic with an occasionally misbehaving destination.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 60 == 0) dest_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if (dest_mode == 1 && $urandom_range(0, 9) == 0) ack_force = $urandom_range(0, 1);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = BW'($urandom);
            if ($urandom_range(0, 399) == 0) begin
                #2;
                reset_now("rand_reset");
                step("rand_in_reset");
                RST = 1'b1;
            end
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_sync_tx.md
Name: data_sync_tx

Overview:
Source-side end of the bus synchronizer handshake. The block accepts a word in the source clock domain and holds it stable on tx_bus while raising the level request tx_req. The destination's synchronizer captures tx_bus on the rising edge of its synchronized tx_req and returns a level acknowledge. This block synchronizes that acknowledge back through NUM_STAGES flops and completes a four-phase (req/ack return-to-zero) handshake before accepting the next word.

Parameters:
NUM_STAGES, 3, depth of the ack synchronizer flop chain (>=2)
BUS_WIDTH, 8, width of the data word
TIMEOUT, 0, cycles allowed in REQ waiting for ack high; 0 disables timeout

Ports:
CLK  input  1  source-domain clock
RST  input  1  asynchronous active-low reset
in_data  input  BUS_WIDTH  word to transfer, sampled on accept
in_valid  input  1  source has a word
in_ready  output  1  block can accept; accept = in_valid & in_ready at posedge CLK
tx_bus  output  BUS_WIDTH  registered data to destination, stable while tx_req high
tx_req  output  1  registered level request to destination (drives destination bus_enable)
ack_async  input  1  level acknowledge from destination, unsynchronized
done  output  1  one-cycle pulse: handshake completed normally
timeout_err  output  1  one-cycle pulse: request aborted by timeout

Behaviour:
- Reset (RST low, asynchronous): state IDLE; tx_req 0; tx_bus 0; done 0; timeout_err 0; ack sync chain 0; timeout counter 0. in_ready is decoded and reads 1.
- ack_sync = last stage of the NUM_STAGES flop chain on ack_async. If ack_async changes before edge Ea, ack_sync takes the new value after edge Ea+NUM_STAGES-1. The FSM acts on it at edge Ea+NUM_STAGES.
- in_ready = (state==IDLE) & ~ack_sync. It is combinational from registers only, with no path from in_valid.
- IDLE: on accept, tx_bus<=in_data and tx_req<=1 at the same edge; go to REQ; clear the counter. A stale ack_sync=1 blocks acceptance; the block stays in IDLE.
- REQ: tx_bus and tx_req are held; in_valid and in_data are ignored.
  - If ack_sync=1: tx_req<=0, go to WAIT_LOW.
  - Else if TIMEOUT!=0 and the counter reaches TIMEOUT-1: tx_req<=0, timeout_err<=1 for one cycle, go to WAIT_LOW.
  - Otherwise: counter increments. Its width is clog2(TIMEOUT+1), minimum 1, and it saturates.
  - If ack and timeout occur on the same edge, ack wins: no timeout_err.
- WAIT_LOW: tx_req stays 0. When ack_sync=0: go to IDLE, and done<=1 for one cycle (only if the exit was not a timeout abort). in_ready rises in the same cycle done is high.
- tx_bus is never cleared after reset. It keeps the last word until the next accept.
- Throughput: at most one word per (2*NUM_STAGES + destination sync latency*2 + ~2) cycles. No buffering.
- Reset mid-transfer: immediate return to reset values. The destination sees tx_req fall. The block must not re-raise tx_req until a new accept.
- All outputs except in_ready are registered.

Decomposition:
- Shared package: state encoding (IDLE, REQ, WAIT_LOW) and a clog2 function for the counter width.
- Natural sub-module: bit_sync, a generic NUM_STAGES single-bit synchronizer (CLK, RST, async_in, sync_out). Instantiate it for ack_async. It is reusable wherever the codebase synchronizes single control bits.

Test Plan:
(NUM_STAGES=3, BUS_WIDTH=8, TIMEOUT=16. Destination model: ack_async = tx_req delayed 3 cycles.)
1. Reset: drive RST low with ack_async=0 -> tx_req=0, tx_bus=0x00, done=0, timeout_err=0, in_ready=1. Hold in_valid=1 during reset -> nothing accepted.
2. Single transfer: pulse in_valid with 0xA5 -> tx_bus=0xA5 and tx_req=1 after the accept edge. tx_req falls exactly 3 edges after ack_async rises. done is high exactly 1 cycle, 3 edges after ack_async falls. in_ready=1 with done.
3. Back-to-back: hold in_valid, in_data=0x11, then change it to 0x22 mid-handshake -> 0x11 is transferred intact. 0x22 is accepted only in the done cycle. tx_bus changes only at the second accept edge.
4. Timeout: tie ack_async=0, accept 0x3C -> tx_req drops after 16 cycles in REQ. timeout_err pulses once; done stays 0. A following 0x5A transfer with a working ack completes normally.
5. Stale ack: ack_async=1 in IDLE, in_valid=1 -> in_ready=0 and no accept. Lower ack_async -> in_ready rises 3 edges later, then the accept occurs.
6. Reset mid-transfer: assert RST while in REQ -> tx_req=0 asynchronously and the state returns to IDLE. After release, no tx_req occurs without a new accept.
